multi_digit_counter_display: RTL and testbench
==============================================

// Module: multi_digit_counter_display
// PURPOSE
//  N-digit cascaded up/down counter with runtime-selectable per-digit radix, parallel load and
//  wrap pulse. Drives a multiplexed, active-low, common-anode 7-segment display.
//  Generalised successor of the single-digit mod-8/10/16 counter. Board-top block, fed from
//  switches/buttons, driving the seven-segment bank directly.
// PARAMETERS
//  N_DIGITS  4      number of cascaded digits / display positions (2..8)
//  TICK_DIV  50000  clock cycles per count step (>=2)
//  SCAN_DIV  500    clock cycles per display position (>=2)
// PORTS
//  clock      in   1           system clock
//  reset      in   1           synchronous, active-high
//  enable     in   1           1 = counting steps permitted
//  load       in   1           1 = parallel load of load_data
//  dir_up     in   1           1 = count up, 0 = count down
//  term       in   4           per-digit terminal value (9 = BCD, 15 = hex, 7 = octal)
//  load_data  in   4*N_DIGITS  digit i at [4i+3:4i]; digit 0 is least significant
//  count      out  4*N_DIGITS  current digit values
//  cout       out  1           one-cycle pulse on full-counter wrap
//  seg_n      out  7           segments g..a, active low
//  an_n       out  N_DIGITS    digit enables, one-hot, active low
// BEHAVIOUR
//  - Reset:
//    - count = 0, cout = 0, prescaler = 0, scan index = 0.
//    - an_n = ~1 (digit 0 enabled), seg_n shows digit 0 ("0" = 7'b1000000).
//  - Effective terminal teff = (term == 0) ? 1 : term.
//  - Prescaler runs free regardless of enable; step = (prescaler == TICK_DIV-1).
//    The prescaler then wraps to 0.
//  - Priority load > step.
//    - load, while enable=1, takes effect next cycle and does not move the prescaler.
//    - Each loaded digit is clamped to teff when greater than teff.
//  - On step with enable=1, a ripple-free single-cycle update:
//    - Up: digit i increments if all lower digits == teff. A digit at teff goes to 0.
//    - Down: digit i decrements if all lower digits == 0. A digit at 0 goes to teff.
//    - Digit 0 always moves.
//  - Any digit found > teff (term lowered at runtime) is forced to 0 on the next step.
//    It generates no carry that step.
//  - cout = 1 for exactly the cycle after a step in which every digit wrapped:
//    up, all == teff -> all 0; down, all 0 -> all teff. Otherwise cout = 0.
//  - enable=0: count and cout frozen (cout = 0); display scanning continues.
//  - Scan:
//    - Scan counter period is SCAN_DIV; on terminal it advances the index 0..N_DIGITS-1.
//    - The index wraps after N_DIGITS-1.
//    - an_n and seg_n are registered and update in the same cycle as the index, glitch-free.
//    - seg_n = hex glyph of the indexed digit, including A-F for values 10-15.
//  - Latency:
//    - load -> count: 1 cycle.
//    - count -> seg_n: at most SCAN_DIV*N_DIGITS cycles.
//  - reset mid-step or mid-scan wins unconditionally on the same edge.
// CONFIGURATION
//  - LEADING_ZERO_BLANK_EN defined:
//    - A digit whose own value and all higher digits' values are 0 displays blank
//      (seg_n = 7'h7F).
//    - Digit 0 is never blanked.
//    - an_n scanning is unchanged.
//  - Not defined: every digit always shows its glyph.
// STRUCTURE
//  - Shared package seg7_pkg:
//    - SEG_BLANK = 7'h7F.
//    - 16-entry active-low hex glyph table / function seg7_hex(nibble).
//    - Digit width constant DIGIT_W = 4.
//  - Sub-module seg7_scan: scan counter, index, an_n/seg_n registers and optional blanking.
//  - Counter and prescaler logic stay in this module.
// TESTING
//  1. TICK_DIV=4, term=9, count 0999, dir_up, enable -> 1000 after one step, cout 0.
//     From 9999 -> 0000 with a single-cycle cout pulse.
//  2. term=15, load_data=16'h00F0, load -> count 00F0 next cycle.
//     dir_up=0, one step -> 00EF; from 0000 -> FFFF with a cout pulse.
//  3. term=7, load_data=16'h9999 -> count 7777 (clamped).
//     load and step in the same cycle -> load wins, no increment.
//  4. term=9, count 0005, enable=0 for 3*TICK_DIV cycles -> count holds 0005, cout stays 0.
//     Re-enable -> 0006 at the next step.
//  5. SCAN_DIV=3, N_DIGITS=4: an_n cycles 1110,1101,1011,0111 every 3 cycles.
//     Digit 0 = 0 -> 1000000; digit = 0xA -> 0001000.
//     With LEADING_ZERO_BLANK_EN and count 0042, digits 3 and 2 -> 7'h7F.
//  6. Assert reset mid-count at 0123 -> count 0000, cout 0, an_n 1110 next cycle.
//     Set term=0 -> digit 0 toggles 0/1 per step.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: digit width, blank pattern and active-low hex glyphs (g..a).
package seg7_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned SEG_W   = 7;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    function automatic logic [SEG_W-1:0] seg7_hex(input logic [DIGIT_W-1:0] nibble);
        logic [SEG_W-1:0] glyph;
        case (nibble)
            4'h0: glyph = 7'b1000000;
            4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;
            4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;
            4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;
            4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;
            4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;
            default: glyph = 7'b0001110;
        endcase
        return glyph;
    endfunction

endpackage

// File: rtl/seg7_scan.sv
// Multiplexed display scanner: walks one anode at a time and latches the matching glyph.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 is always shown).
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int unsigned N_DIGITS = 4,
    parameter int unsigned SCAN_DIV = 500
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [N_DIGITS*DIGIT_W-1:0]   count,
    output logic [SEG_W-1:0]              seg_n,
    output logic [N_DIGITS-1:0]           an_n
);

    localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int unsigned SCN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [SCN_W-1:0]   scan_cnt;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   idx_nxt_c;
    logic [DIGIT_W-1:0] digits_c [N_DIGITS];
    logic               advance_c;
    logic               blank_c;
`ifdef LEADING_ZERO_BLANK_EN
    logic               upper_zero_c;
`endif

    assign advance_c = (scan_cnt == SCN_W'(SCAN_DIV - 1));

    // Next index, its digit value, and whether that digit is a leading zero
    always_comb begin
        idx_nxt_c = (idx == IDX_W'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
        for (int i = 0; i < int'(N_DIGITS); i++) begin
            digits_c[i] = count[i*DIGIT_W +: DIGIT_W];
        end
        blank_c = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        upper_zero_c = 1'b1;
        for (int i = int'(N_DIGITS) - 1; i >= 1; i--) begin
            upper_zero_c = upper_zero_c && (digits_c[i] == '0);
            if (IDX_W'(i) == idx_nxt_c) begin
                blank_c = upper_zero_c;
            end
        end
`endif
    end

    // Anode and segment registers move together with the index so the bank never shows a mix
    always_ff @(posedge clock) begin
        if (reset) begin
            scan_cnt <= '0;
            idx      <= '0;
            an_n     <= ~N_DIGITS'(1);
            seg_n    <= seg7_hex(DIGIT_W'(0));
        end else if (advance_c) begin
            scan_cnt <= '0;
            idx      <= idx_nxt_c;
            an_n     <= ~(N_DIGITS'(1) << idx_nxt_c);
            seg_n    <= blank_c ? SEG_BLANK : seg7_hex(digits_c[idx_nxt_c]);
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/multi_digit_counter_display.sv
// N-digit cascaded up/down counter with runtime radix, clamped parallel load and wrap pulse,
// driving a multiplexed active-low 7-segment bank. Build option: LEADING_ZERO_BLANK_EN.
module multi_digit_counter_display
    import seg7_pkg::*;
#(
    parameter int unsigned N_DIGITS = 4,
    parameter int unsigned TICK_DIV = 50000,
    parameter int unsigned SCAN_DIV = 500
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          load,
    input  logic                          dir_up,
    input  logic [DIGIT_W-1:0]            term,
    input  logic [N_DIGITS*DIGIT_W-1:0]   load_data,
    output logic [N_DIGITS*DIGIT_W-1:0]   count,
    output logic                          cout,
    output logic [SEG_W-1:0]              seg_n,
    output logic [N_DIGITS-1:0]           an_n
);

    localparam int unsigned CNT_W = N_DIGITS * DIGIT_W;
    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PRE_W-1:0]   presc;
    logic               step_c;
    logic [DIGIT_W-1:0] teff_c;
    logic [CNT_W-1:0]   count_step_c;
    logic [CNT_W-1:0]   count_load_c;
    logic               carry_up_c;
    logic               carry_dn_c;
    logic               wrap_c;

    assign step_c = (presc == PRE_W'(TICK_DIV - 1));
    assign teff_c = (term == '0) ? DIGIT_W'(1) : term;

    // Single-cycle cascade: a digit moves when every lower digit sits at its wrap value
    always_comb begin
        count_step_c = count;
        carry_up_c   = 1'b1;
        carry_dn_c   = 1'b1;
        for (int i = 0; i < int'(N_DIGITS); i++) begin
            if (count[i*DIGIT_W +: DIGIT_W] > teff_c) begin
                count_step_c[i*DIGIT_W +: DIGIT_W] = '0;
            end else if (dir_up && carry_up_c) begin
                count_step_c[i*DIGIT_W +: DIGIT_W] =
                    (count[i*DIGIT_W +: DIGIT_W] == teff_c) ? '0 : count[i*DIGIT_W +: DIGIT_W] + 1'b1;
            end else if (!dir_up && carry_dn_c) begin
                count_step_c[i*DIGIT_W +: DIGIT_W] =
                    (count[i*DIGIT_W +: DIGIT_W] == '0) ? teff_c : count[i*DIGIT_W +: DIGIT_W] - 1'b1;
            end
            // Out-of-range digits match neither 0 nor teff, so they also break the carry
            carry_up_c = carry_up_c && (count[i*DIGIT_W +: DIGIT_W] == teff_c);
            carry_dn_c = carry_dn_c && (count[i*DIGIT_W +: DIGIT_W] == '0);
        end
        wrap_c = dir_up ? carry_up_c : carry_dn_c;
    end

    // Load data with each digit clamped to the current terminal value
    always_comb begin
        count_load_c = load_data;
        for (int i = 0; i < int'(N_DIGITS); i++) begin
            if (load_data[i*DIGIT_W +: DIGIT_W] > teff_c) begin
                count_load_c[i*DIGIT_W +: DIGIT_W] = teff_c;
            end
        end
    end

    // Free-running prescaler; load has priority over a step and leaves the prescaler alone
    always_ff @(posedge clock) begin
        if (reset) begin
            presc <= '0;
            count <= '0;
            cout  <= 1'b0;
        end else begin
            presc <= step_c ? '0 : presc + 1'b1;
            cout  <= 1'b0;
            if (enable) begin
                if (load) begin
                    count <= count_load_c;
                end else if (step_c) begin
                    count <= count_step_c;
                    cout  <= wrap_c;
                end
            end
        end
    end

    seg7_scan #(
        .N_DIGITS (N_DIGITS),
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .clock (clock),
        .reset (reset),
        .count (count),
        .seg_n (seg_n),
        .an_n  (an_n)
    );

endmodule

// File: tb/tb_multi_digit_counter_display.sv
// Bench for multi_digit_counter_display: directed scenarios plus random stimulus against a
// mixed-radix arithmetic reference model. Honours LEADING_ZERO_BLANK_EN like the design.
module tb_multi_digit_counter_display;

    localparam int N  = 4;
    localparam int TD = 4;
    localparam int SD = 3;

    logic          clock = 1'b0;
    logic          reset;
    logic          enable;
    logic          load;
    logic          dir_up;
    logic [3:0]    term;
    logic [4*N-1:0] load_data;
    logic [4*N-1:0] count;
    logic          cout;
    logic [6:0]    seg_n;
    logic [N-1:0]  an_n;

    multi_digit_counter_display #(
        .N_DIGITS (N),
        .TICK_DIV (TD),
        .SCAN_DIV (SD)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .load      (load),
        .dir_up    (dir_up),
        .term      (term),
        .load_data (load_data),
        .count     (count),
        .cout      (cout),
        .seg_n     (seg_n),
        .an_n      (an_n)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Independent glyph table, segments g..a, active low
    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model state
    int         m_dig [N];
    bit         m_cout;
    int         m_presc;
    int         m_scnt;
    int         m_idx;
    logic [N-1:0] m_an;
    logic [6:0] m_seg;
    bit         m_valid = 1'b0;

    function automatic logic [4*N-1:0] packm();
        logic [4*N-1:0] r;
        for (int i = 0; i < N; i++) r[i*4 +: 4] = 4'(m_dig[i]);
        return r;
    endfunction

    function automatic logic [6:0] disp_glyph(input int k);
`ifdef LEADING_ZERO_BLANK_EN
        bit lead = (k != 0);
        for (int i = k; i < N; i++) if (m_dig[i] != 0) lead = 1'b0;
        if (lead) return 7'h7F;
`endif
        return glyph[m_dig[k]];
    endfunction

    // One count step: digits below the lowest out-of-range digit behave as one base-(teff+1) number
    task automatic model_step();
        int teff, base, j, low, modv, nl, pw;
        bit wrap;
        teff = (term == 0) ? 1 : int'(term);
        base = teff + 1;
        j = N;
        for (int i = N - 1; i >= 0; i--) if (m_dig[i] > teff) j = i;
        low = 0; pw = 1;
        for (int i = 0; i < j; i++) begin low += m_dig[i] * pw; pw *= base; end
        modv = pw;
        if (dir_up) begin
            nl = (low + 1) % modv;
            wrap = (low + 1 == modv);
        end else begin
            nl = (low + modv - 1) % modv;
            wrap = (low == 0);
        end
        for (int i = 0; i < j; i++) begin m_dig[i] = nl % base; nl = nl / base; end
        for (int i = j; i < N; i++) if (m_dig[i] > teff) m_dig[i] = 0;
        m_cout = wrap && (j == N);
    endtask

    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N; i++) m_dig[i] = 0;
            m_cout = 0; m_presc = 0; m_scnt = 0; m_idx = 0;
            m_an = ~N'(1);
            m_seg = glyph[0];
        end else begin
            bit step;
            int teff;
            step = (m_presc == TD - 1);
            m_presc = step ? 0 : m_presc + 1;
            if (m_scnt == SD - 1) begin
                m_scnt = 0;
                m_idx = (m_idx + 1) % N;
                m_an = ~(N'(1) << m_idx);
                m_seg = disp_glyph(m_idx);
            end else begin
                m_scnt++;
            end
            m_cout = 0;
            if (enable) begin
                teff = (term == 0) ? 1 : int'(term);
                if (load) begin
                    for (int i = 0; i < N; i++) begin
                        m_dig[i] = int'(load_data[i*4 +: 4]);
                        if (m_dig[i] > teff) m_dig[i] = teff;
                    end
                end else if (step) begin
                    model_step();
                end
            end
        end
        m_valid = 1'b1;
    end

    always @(negedge clock) begin
        if (m_valid) begin
            check("count", 32'(count), 32'(packm()));
            check("cout", 32'(cout), 32'(m_cout));
            check("an_n", 32'(an_n), 32'(m_an));
            check("seg_n", 32'(seg_n), 32'(m_seg));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_load(input logic [4*N-1:0] d);
        enable = 1'b1; load = 1'b1; load_data = d;
        tick(1);
        load = 1'b0;
    endtask

    task automatic wait_cout(input string tag, input logic [4*N-1:0] exp_cnt);
        bit seen = 1'b0;
        for (int k = 0; k < TD + 2 && !seen; k++) begin
            @(negedge clock);
            if (cout === 1'b1) seen = 1'b1;
        end
        check({tag, "_seen"}, 32'(seen), 32'd1);
        check({tag, "_cnt"}, 32'(count), 32'(exp_cnt));
        @(negedge clock);
        check({tag, "_pulse1"}, 32'(cout), 32'd0);
        @(posedge clock); #1;
    endtask

    task automatic wait_an(input logic [N-1:0] pat);
        bit seen = 1'b0;
        for (int k = 0; k < 2 * SD * N && !seen; k++) begin
            @(negedge clock);
            if (an_n === pat) seen = 1'b1;
        end
        check("an_reach", 32'(seen), 32'd1);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; load = 1'b0; dir_up = 1'b1;
        term = 4'd9; load_data = '0;
        tick(2);
        check("rst_count", 32'(count), 32'h0);
        check("rst_an", 32'(an_n), 32'(4'b1110));
        check("rst_seg", 32'(seg_n), 32'(7'b1000000));
        reset = 1'b0;

        // BCD cascade and full wrap
        term = 4'd9; dir_up = 1'b1;
        do_load(16'h0999);
        check("t1_load", 32'(count), 32'h0999);
        tick(TD);
        check("t1_carry", 32'(count), 32'h1000);
        check("t1_cout0", 32'(cout), 32'd0);
        do_load(16'h9999);
        wait_cout("t1_wrap", 16'h0000);

        // Hex down-count and underflow wrap
        term = 4'd15;
        do_load(16'h00F0);
        check("t2_load", 32'(count), 32'h00F0);
        dir_up = 1'b0;
        tick(TD);
        check("t2_down", 32'(count), 32'h00EF);
        do_load(16'h0000);
        wait_cout("t2_wrap", 16'hFFFF);

        // Octal clamp and load-over-step priority
        term = 4'd7; dir_up = 1'b1;
        do_load(16'h9999);
        check("t3_clamp", 32'(count), 32'h7777);
        for (int k = 0; k < TD && m_presc != TD - 1; k++) tick(1);
        check("t3_align", 32'(m_presc), 32'(TD - 1));
        do_load(16'h0123);
        check("t3_prio", 32'(count), 32'h0123);

        // Freeze while disabled
        term = 4'd9;
        do_load(16'h0005);
        enable = 1'b0;
        tick(3 * TD);
        check("t4_hold", 32'(count), 32'h0005);
        check("t4_cout", 32'(cout), 32'd0);
        enable = 1'b1;
        tick(TD);
        check("t4_resume", 32'(count), 32'h0006);

        // Display glyphs
        term = 4'd15;
        do_load(16'h00A0);
        enable = 1'b0;
        tick(SD * N);
        wait_an(4'b1101);
        check("t5_glyph_a", 32'(seg_n), 32'(7'b0001000));
        wait_an(4'b1110);
        check("t5_glyph_0", 32'(seg_n), 32'(7'b1000000));
        @(posedge clock); #1;
        do_load(16'h0042);
        enable = 1'b0;
        tick(SD * N);
        wait_an(4'b0111);
`ifdef LEADING_ZERO_BLANK_EN
        check("t5_blank3", 32'(seg_n), 32'h7F);
`else
        check("t5_glyph3", 32'(seg_n), 32'(7'b1000000));
`endif
        @(posedge clock); #1;

        // Reset mid-count, then term=0 toggling
        term = 4'd9; dir_up = 1'b1;
        do_load(16'h0123);
        tick(2);
        reset = 1'b1;
        tick(1);
        check("t6_count", 32'(count), 32'h0);
        check("t6_cout", 32'(cout), 32'd0);
        check("t6_an", 32'(an_n), 32'(4'b1110));
        reset = 1'b0;
        term = 4'd0; enable = 1'b1;
        tick(TD);
        check("t6_tog1", 32'(count[3:0]), 32'd1);
        tick(TD);
        check("t6_tog0", 32'(count[3:0]), 32'd0);

        // Random traffic against the model
        for (int it = 0; it < 3000; it++) begin
            reset  = ($urandom_range(0, 299) == 0);
            enable = ($urandom_range(0, 4) != 0);
            load   = ($urandom_range(0, 11) == 0);
            load_data = 16'($urandom);
            if ($urandom_range(0, 19) == 0) dir_up = ~dir_up;
            if ($urandom_range(0, 39) == 0) begin
                case ($urandom_range(0, 4))
                    0: term = 4'd9;
                    1: term = 4'd15;
                    2: term = 4'd7;
                    3: term = 4'd0;
                    default: term = 4'($urandom);
                endcase
            end
            tick(1);
        end

        reset = 1'b0; load = 1'b0;
        tick(1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
